// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache line refill controller (optional CACHE_REFILL_CRIT_WORD_EN: critical-word-first)
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [31:0]           miss_addr_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [31:0]           mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [BEAT_WIDTH-1:0] mem_rsp_data_i,
    output logic                  set_we_o,
    output logic [ADDR_WIDTH-1:0] set_addr_o,
    output logic [DATA_WIDTH-1:0] set_wdata_o,
    output logic [1:0]            set_width_o,
    input  logic                  set_misaligned_i,
    output logic                  fill_done_o,
    output logic                  fill_err_o,
    output logic                  crit_valid_o,
    output logic [BEAT_WIDTH-1:0] crit_data_o
);
    localparam int BEATS    = DATA_WIDTH / BEAT_WIDTH;
    localparam int LANE_W   = $clog2(BEATS);
    localparam int CNT_W    = LANE_W + 1;
    localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam logic [31:0] LINE_MASK = 32'(DATA_WIDTH / 8 - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_WRITE, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] line_q, line_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] set_addr_q, set_addr_d;
    logic                  err_q, err_d;
    logic [LANE_W-1:0]     lane;
    logic                  accept;
    logic                  beat_fire;
    logic                  last_beat;

    assign accept    = (state_q == S_IDLE) && miss_valid_i;
    assign beat_fire = (state_q == S_RECV) && mem_rsp_valid_i;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

`ifdef CACHE_REFILL_CRIT_WORD_EN
    localparam int BEAT_OFF = $clog2(BEAT_WIDTH / 8);
    localparam logic [31:0] BEAT_MASK = 32'(BEAT_WIDTH / 8 - 1);

    // The burst starts at the missing word, so lanes wrap around from it.
    assign lane           = addr_q[OFF_BITS-1:BEAT_OFF] + cnt_q[LANE_W-1:0];
    assign mem_req_addr_o = addr_q & ~BEAT_MASK;
    assign crit_valid_o   = beat_fire && (cnt_q == '0);
    assign crit_data_o    = crit_valid_o ? mem_rsp_data_i : '0;
`else
    assign lane           = cnt_q[LANE_W-1:0];
    assign mem_req_addr_o = addr_q & ~LINE_MASK;
    assign crit_valid_o   = 1'b0;
    assign crit_data_o    = '0;
`endif

    assign set_width_o = 2'b00;
    assign set_addr_o  = set_addr_q;
    assign set_wdata_o = wdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (miss_valid_i) state_d = S_REQ;
            S_REQ:   if (mem_req_ready_i) state_d = S_RECV;
            S_RECV:  if (mem_rsp_valid_i && last_beat) state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        miss_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        set_we_o        = 1'b0;
        fill_done_o     = 1'b0;
        fill_err_o      = 1'b0;
        case (state_q)
            S_IDLE:  miss_ready_o = 1'b1;
            S_REQ:   mem_req_valid_o = 1'b1;
            S_WRITE: set_we_o = 1'b1;
            S_DONE: begin
                fill_done_o = 1'b1;
                fill_err_o  = err_q;
            end
            default: ;
        endcase
    end

    // The write-port registers load on the final beat so they are valid
    // throughout WRITE and keep their value afterwards.
    always_comb begin
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        wdata_d    = wdata_q;
        set_addr_d = set_addr_q;
        err_d      = err_q;
        if (accept) begin
            addr_d = miss_addr_i;
            cnt_d  = '0;
            line_d = '0;
            err_d  = 1'b0;
        end
        if (beat_fire) begin
            line_d[lane*BEAT_WIDTH +: BEAT_WIDTH] = mem_rsp_data_i;
            cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
            if (last_beat) begin
                wdata_d    = line_d;
                set_addr_d = addr_q[ADDR_WIDTH-1:0] & ~LINE_MASK[ADDR_WIDTH-1:0];
            end
        end
        if (state_q == S_WRITE) begin
            err_d = set_misaligned_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            line_q     <= '0;
            wdata_q    <= '0;
            set_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            wdata_q    <= wdata_d;
            set_addr_q <= set_addr_d;
            err_q      <= err_d;
        end
    end
endmodule
